// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared seven-segment definitions used by the display decoder and by
// seg7_hex_capture. Contents:
//   SEG_CODE  : 16 legal hex-digit patterns, indexed by digit value
//   SEG_BLANK : all-segments-off pattern
//   state_t   : capture FSM states (COLLECT, HOLD)
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg7_pkg;

    // Packed so that SEG_CODE[n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // D
        7'b1000110,  // C
        7'b0000011,  // B
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_nibble.sv
// seg7_to_nibble
// Combinational lookup of a seven-segment pattern into its hex value.
// Ports:
//   segments : 7-bit active-low pattern {g,f,e,d,c,b,a}
//   nibble   : decoded hex value (0 when not legal)
//   legal    : pattern is one of the 16 hex digit codes
//   blank    : pattern is the all-off blank code
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (segments == SEG_CODE[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
        blank = (segments == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_hex_capture.sv
// seg7_hex_capture
// Samples strobed seven-segment patterns, assembles DIGITS hex digits into a
// word (first digit in the most significant nibble) and holds the finished
// word with a valid/ready handshake.
// Ports:
//   i_Clock, i_Reset   : clock, asynchronous active-high reset
//   i_Segments         : active-low pattern {g,f,e,d,c,b,a}, sampled on i_Strobe
//   i_Ready            : consumer accepts o_Word when o_Valid is high
//   o_Word             : finished word when o_Valid, else partial accumulator
//   o_Valid            : word complete and held
//   o_DigitCount       : digits captured for the word in progress
//   o_Error            : one-cycle pulse, strobed pattern was not a legal code
//   o_Overrun          : one-cycle pulse, strobe arrived while word held
module seg7_hex_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [6:0]            i_Segments,
    input  logic                  i_Strobe,
    input  logic                  i_Ready,
    output logic [4*DIGITS-1:0]   o_Word,
    output logic                  o_Valid,
    output logic [3:0]            o_DigitCount,
    output logic                  o_Error,
    output logic                  o_Overrun
);

    localparam int         W        = 4 * DIGITS;
    localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

    state_t         state, state_nxt;
    logic [W-1:0]   acc, acc_nxt, base_acc, nib_ext;
    logic [3:0]     cnt, cnt_nxt, base_cnt;
    logic           err_nxt, ovr_nxt, collecting;
    logic [3:0]     nibble;
    logic           legal, blank;

    seg7_to_nibble u_dec (
        .segments (i_Segments),
        .nibble   (nibble),
        .legal    (legal),
        .blank    (blank)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= COLLECT;
            acc       <= '0;
            cnt       <= '0;
            o_Error   <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            o_Error   <= err_nxt;
            o_Overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        err_nxt    = 1'b0;
        ovr_nxt    = 1'b0;
        base_acc   = acc;
        base_cnt   = cnt;
        collecting = (state == COLLECT);
        nib_ext    = '0;
        nib_ext[3:0] = nibble;

        // A transfer frees the accumulator in the same cycle, so a strobe
        // arriving now is treated as the first digit of a fresh word.
        if (state == HOLD && i_Ready) begin
            state_nxt  = COLLECT;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            base_acc   = '0;
            base_cnt   = '0;
            collecting = 1'b1;
        end

        if (i_Strobe) begin
            if (!collecting) begin
                ovr_nxt = 1'b1;
            end else if (blank) begin
                // blank digit position: nothing to capture
            end else if (!legal) begin
                err_nxt = 1'b1;
                acc_nxt = '0;
                cnt_nxt = '0;
            end else begin
                acc_nxt = (base_acc << 4) | nib_ext;
                if (base_cnt == LAST_IDX) begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = base_cnt + 4'd1;
                end
            end
        end
    end

    assign o_Word       = acc;
    assign o_Valid      = (state == HOLD);
    assign o_DigitCount = cnt;

endmodule

// File: tb/tb_seg7_hex_capture.sv
module tb_seg7_hex_capture;

    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        seg = 7'h7F;
    logic              stb = 1'b0;
    logic              rdy = 1'b0;
    logic [4*DIGITS-1:0] word;
    logic              valid, err, ovr;
    logic [3:0]        dcnt;

    int total = 0;
    int bad   = 0;

    // behavioural reference state
    int      m_digits[$];
    bit      m_valid;
    longint  m_word;
    bit      m_err, m_ovr;

    seg7_hex_capture #(.DIGITS(DIGITS)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Segments   (seg),
        .i_Strobe     (stb),
        .i_Ready      (rdy),
        .o_Word       (word),
        .o_Valid      (valid),
        .o_DigitCount (dcnt),
        .o_Error      (err),
        .o_Overrun    (ovr)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0011000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    // -1 = illegal, 16 = blank, else digit value
    function automatic int decode(input logic [6:0] s);
        if (s == 7'b1111111) return 16;
        for (int i = 0; i < 16; i++) if (pat(i) == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_valid = 0; m_word = 0; m_err = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit s, input logic [6:0] p, input bit r);
        int d;
        m_err = 0; m_ovr = 0;
        if (m_valid && r) begin
            m_valid = 0;
            m_digits.delete();
        end
        if (s) begin
            d = decode(p);
            if (m_valid) m_ovr = 1;
            else if (d == 16) ;
            else if (d < 0) begin m_err = 1; m_digits.delete(); end
            else begin
                m_digits.push_back(d);
                if (m_digits.size() == DIGITS) begin
                    m_word = 0;
                    foreach (m_digits[i]) m_word = m_word * 16 + m_digits[i];
                    m_valid = 1;
                    m_digits.delete();
                end
            end
        end
    endtask

    // apply inputs for one cycle, clock once, leave time at edge+1
    task automatic cyc(input bit s, input logic [6:0] p, input bit r);
        stb = s; seg = p; rdy = r;
        model_step(s, p, r);
        @(posedge clk);
        #1;
        stb = 1'b0; rdy = 1'b0;
    endtask

    task automatic digit(input int d);
        cyc(1'b1, pat(d), 1'b0);
    endtask

    task automatic idle(input bit r);
        cyc(1'b0, 7'h7F, r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        total++;
        if ({word, valid, dcnt, err, ovr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got word=%h v=%b cnt=%0d e=%b o=%b, want all 0", word, valid, dcnt, err, ovr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({valid, dcnt} !== '0) begin
            bad++;
            $display("FAIL reset_idle: got v=%b cnt=%0d, want 0 0", valid, dcnt);
        end
    endtask

    task automatic test_basic();
        digit(2); digit(3); digit(4);
        total++;
        if (valid !== 1'b0 || dcnt !== 4'd3) begin
            bad++;
            $display("FAIL basic_partial: got v=%b cnt=%0d, want 0 3", valid, dcnt);
        end
        digit(5);
        total++;
        if (valid !== 1'b1 || word !== 16'h2345 || dcnt !== 4'd0) begin
            bad++;
            $display("FAIL basic_word: got v=%b w=%h cnt=%0d, want 1 2345 0", valid, word, dcnt);
        end
        idle(1'b0); idle(1'b0);
        total++;
        if (valid !== 1'b1 || word !== 16'h2345) begin
            bad++;
            $display("FAIL basic_hold: got v=%b w=%h, want 1 2345", valid, word);
        end
        idle(1'b1);
        total++;
        if (valid !== 1'b0 || word !== 16'h0000) begin
            bad++;
            $display("FAIL basic_accept: got v=%b w=%h, want 0 0000", valid, word);
        end
    endtask

    task automatic test_blank();
        digit(1);
        cyc(1'b1, 7'b1111111, 1'b0);
        total++;
        if (dcnt !== 4'd1 || err !== 1'b0) begin
            bad++;
            $display("FAIL blank_count: got cnt=%0d e=%b, want 1 0", dcnt, err);
        end
        digit(0); digit(10); digit(11);
        total++;
        if (valid !== 1'b1 || word !== 16'h10AB) begin
            bad++;
            $display("FAIL blank_word: got v=%b w=%h, want 1 10ab", valid, word);
        end
        idle(1'b1);
    endtask

    task automatic test_error();
        digit(6); digit(7);
        cyc(1'b1, 7'b1010101, 1'b0);
        total++;
        if (err !== 1'b1 || dcnt !== 4'd0 || word !== 16'h0) begin
            bad++;
            $display("FAIL error_pulse: got e=%b cnt=%0d w=%h, want 1 0 0000", err, dcnt, word);
        end
        digit(15);
        total++;
        if (err !== 1'b0 || dcnt !== 4'd1) begin
            bad++;
            $display("FAIL error_single: got e=%b cnt=%0d, want 0 1", err, dcnt);
        end
        digit(14); digit(13); digit(12);
        total++;
        if (valid !== 1'b1 || word !== 16'hFEDC) begin
            bad++;
            $display("FAIL error_word: got v=%b w=%h, want 1 fedc", valid, word);
        end
        idle(1'b1);
    endtask

    task automatic test_overrun();
        digit(1); digit(2); digit(3); digit(4);
        digit(7);
        total++;
        if (ovr !== 1'b1 || valid !== 1'b1 || word !== 16'h1234) begin
            bad++;
            $display("FAIL overrun_pulse: got o=%b v=%b w=%h, want 1 1 1234", ovr, valid, word);
        end
        cyc(1'b1, 7'b1010101, 1'b0);
        total++;
        if (ovr !== 1'b1 || err !== 1'b0 || word !== 16'h1234) begin
            bad++;
            $display("FAIL overrun_illegal: got o=%b e=%b w=%h, want 1 0 1234", ovr, err, word);
        end
        cyc(1'b1, pat(8), 1'b1);
        total++;
        if (valid !== 1'b0 || dcnt !== 4'd1 || ovr !== 1'b0) begin
            bad++;
            $display("FAIL overrun_accept: got v=%b cnt=%0d o=%b, want 0 1 0", valid, dcnt, ovr);
        end
        digit(1); digit(2); digit(3);
        total++;
        if (valid !== 1'b1 || word !== 16'h8123) begin
            bad++;
            $display("FAIL overrun_next: got v=%b w=%h, want 1 8123", valid, word);
        end
        idle(1'b1);
    endtask

    task automatic test_async_reset();
        digit(3); digit(3); digit(3);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({word, valid, dcnt, err, ovr} !== '0) begin
            bad++;
            $display("FAIL async_reset: got w=%h v=%b cnt=%0d, want all 0", word, valid, dcnt);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        digit(9); digit(9); digit(9); digit(9);
        total++;
        if (valid !== 1'b1 || word !== 16'h9999) begin
            bad++;
            $display("FAIL async_word: got v=%b w=%h, want 1 9999", valid, word);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        int k;
        logic [6:0] p;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k < 7)       p = pat($urandom_range(0, 15));
            else if (k == 7) p = 7'b1111111;
            else             p = 7'($urandom_range(0, 127));
            cyc(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 2) == 0));
            total++;
            if (valid !== m_valid || dcnt !== 4'(m_digits.size()) || err !== m_err || ovr !== m_ovr ||
                (m_valid && word !== 16'(m_word))) begin
                bad++;
                $display("FAIL random_%0d: got v=%b w=%h cnt=%0d e=%b o=%b, want v=%b w=%h cnt=%0d e=%b o=%b",
                         n, valid, word, dcnt, err, ovr, m_valid, 16'(m_word), m_digits.size(), m_err, m_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_error();
        test_overrun();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
